// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (if_*) and load/store (ls_*).
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_rsp_valid,
    input  logic          if_rsp_ready,
    output logic [DW-1:0] if_rsp_rdata,

    input  logic          ls_req_valid,
    output logic          ls_req_ready,
    input  logic [AW-1:0] ls_req_addr,
    input  logic          ls_req_we,
    input  logic [DW-1:0] ls_req_wdata,
    input  logic [3:0]    ls_req_wstrb,
    output logic          ls_rsp_valid,
    input  logic          ls_rsp_ready,
    output logic [DW-1:0] ls_rsp_rdata,

    output logic          m_req_valid,
    input  logic          m_req_ready,
    output logic [AW-1:0] m_req_addr,
    output logic          m_req_we,
    output logic [DW-1:0] m_req_wdata,
    output logic [3:0]    m_req_wstrb,
    input  logic          m_rsp_valid,
    output logic          m_rsp_ready,
    input  logic [DW-1:0] m_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t r_state;
    logic   r_owner;

    logic   w_idle;
    logic   w_resp;
    logic   w_ls_first;
    logic   w_grant_ls;
    logic   w_grant_if;
    logic   w_hs;

`ifdef MEM_ARB_RR_EN
    logic   r_last;

    // On a tie the requester that did not win last time goes first.
    assign w_ls_first = ~if_req_valid | ~r_last;
`else
    assign w_ls_first = 1'b1;
`endif

    assign w_idle     = rst_n & (r_state == S_IDLE);
    assign w_resp     = (r_state == S_RESP);
    assign w_grant_ls = ls_req_valid & w_ls_first;
    assign w_grant_if = if_req_valid & ~w_grant_ls;
    assign w_hs       = w_idle & (w_grant_ls | w_grant_if);

    assign if_req_ready = w_idle & w_grant_if;
    assign ls_req_ready = w_idle & w_grant_ls;

    assign m_rsp_ready  = w_resp & (r_owner ? ls_rsp_ready : if_rsp_ready);
    assign if_rsp_valid = w_resp & ~r_owner & m_rsp_valid;
    assign ls_rsp_valid = w_resp &  r_owner & m_rsp_valid;
    assign if_rsp_rdata = (w_resp & ~r_owner) ? m_rsp_rdata : '0;
    assign ls_rsp_rdata = (w_resp &  r_owner) ? m_rsp_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last      <= 1'b0;
`endif
            m_req_valid <= 1'b0;
            m_req_addr  <= '0;
            m_req_we    <= 1'b0;
            m_req_wdata <= '0;
            m_req_wstrb <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_state     <= S_REQ;
                        r_owner     <= w_grant_ls;
`ifdef MEM_ARB_RR_EN
                        r_last      <= w_grant_ls;
`endif
                        m_req_valid <= 1'b1;
                        m_req_addr  <= w_grant_ls ? ls_req_addr : if_req_addr;
                        m_req_we    <= w_grant_ls & ls_req_we;
                        m_req_wdata <= w_grant_ls ? ls_req_wdata : '0;
                        m_req_wstrb <= w_grant_ls ? ls_req_wstrb : 4'h0;
                    end
                end
                S_REQ: begin
                    if (m_req_ready) begin
                        r_state     <= S_RESP;
                        m_req_valid <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (m_rsp_valid && m_rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    m_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized
// run checked against a transaction-level model of the shared memory port.
`timescale 1ns/100ps
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [31:0] if_rsp_rdata;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_req_addr;
    logic        ls_req_we;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_wstrb;
    logic        ls_rsp_valid;
    logic        ls_rsp_ready;
    logic [31:0] ls_rsp_rdata;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_req_addr;
    logic        m_req_we;
    logic [31:0] m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic        m_rsp_valid;
    logic        m_rsp_ready;
    logic [31:0] m_rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_rdata (if_rsp_rdata),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_req_addr  (ls_req_addr),
        .ls_req_we    (ls_req_we),
        .ls_req_wdata (ls_req_wdata),
        .ls_req_wstrb (ls_req_wstrb),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_ready (ls_rsp_ready),
        .ls_rsp_rdata (ls_rsp_rdata),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_addr   (m_req_addr),
        .m_req_we     (m_req_we),
        .m_req_wdata  (m_req_wdata),
        .m_req_wstrb  (m_req_wstrb),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_ready  (m_rsp_ready),
        .m_rsp_rdata  (m_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit ifv;
        bit lsv;
        bit mrv;
        bit exp_ifr;
        bit exp_lsr;
    } vec_t;

    vec_t vt[6];

    bit [31:0] mem_m [bit [31:0]];

    bit        if_pend, ls_pend, ls_we, t_own, t_we, rr_last, win_ls, win_if, exp_mrr;
    bit [31:0] if_a, ls_a, ls_wd, t_addr, t_wd, rsp_val, drv_rdata;
    bit [3:0]  ls_ws, t_ws;
    int        phase, dly, ntx;
    int        order[6];
    int        exp_order[6];
    int        ni, nl, ng;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 0; if_req_addr = 0; if_rsp_ready = 0;
        ls_req_valid = 0; ls_req_addr = 0; ls_req_we = 0;
        ls_req_wdata = 0; ls_req_wstrb = 0; ls_rsp_ready = 0;
        m_req_ready = 0; m_rsp_valid = 0; m_rsp_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
    endtask

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : {a[15:0], ~a[15:0]};
    endfunction

    task automatic mem_wr(input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
        bit [31:0] cur;
        cur = mem_rd(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        mem_m[a] = cur;
    endtask

    initial begin
        vt[0] = '{0, 0, 0, 0, 0};
        vt[1] = '{1, 0, 0, 1, 0};
        vt[2] = '{0, 1, 0, 0, 1};
        vt[3] = '{1, 1, 0, 0, 1};
        vt[4] = '{1, 1, 1, 0, 1};
        vt[5] = '{0, 0, 1, 0, 0};
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 0, 0, 0};
`endif

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_ctrl", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                         m_req_valid, m_req_we, m_rsp_ready, m_req_wstrb}, 0);
        chk("rst_addr", m_req_addr, 0);
        chk("rst_wdata", m_req_wdata, 0);
        chk("rst_rdata", {if_rsp_rdata, ls_rsp_rdata}, 0);
        tick();

        // Idle arbitration table, no clock edge crossed
        foreach (vt[i]) begin
            if_req_valid = vt[i].ifv;
            ls_req_valid = vt[i].lsv;
            m_rsp_valid  = vt[i].mrv;
            #1;
            chk($sformatf("tbl%0d_if_ready", i), if_req_ready, vt[i].exp_ifr);
            chk($sformatf("tbl%0d_ls_ready", i), ls_req_ready, vt[i].exp_lsr);
            chk($sformatf("tbl%0d_rsp", i), {m_rsp_ready, if_rsp_valid, ls_rsp_valid}, 0);
        end
        idle_inputs();

        // IF fetch, memory ready at once
        do_reset();
        if_req_valid = 1; if_req_addr = 32'h100;
        @(negedge clk);
        chk("t2_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 0; if_req_addr = 0; m_req_ready = 1;
        @(negedge clk);
        chk("t2_m_valid", m_req_valid, 1);
        chk("t2_m_addr", m_req_addr, 32'h100);
        chk("t2_m_we", {m_req_we, m_req_wdata, m_req_wstrb}, 0);
        tick();
        m_req_ready = 0; m_rsp_valid = 1; m_rsp_rdata = 32'h13; if_rsp_ready = 1;
        @(negedge clk);
        chk("t2_if_rsp_valid", if_rsp_valid, 1);
        chk("t2_if_rdata", if_rsp_rdata, 32'h13);
        chk("t2_m_rsp_ready", m_rsp_ready, 1);
        chk("t2_ls_rsp_valid", ls_rsp_valid, 0);
        tick();
        m_rsp_valid = 0; if_rsp_ready = 0; if_req_valid = 1;
        @(negedge clk);
        chk("t2_idle_again", if_req_ready, 1);
        #1 if_req_valid = 0;
        tick();

        // LS store with memory stall and spurious responses in REQ
        do_reset();
        ls_req_valid = 1; ls_req_addr = 32'h2000; ls_req_we = 1;
        ls_req_wdata = 32'hDEADBEEF; ls_req_wstrb = 4'hF;
        @(negedge clk);
        chk("t3_ls_ready", ls_req_ready, 1);
        tick();
        ls_req_valid = 0; ls_req_addr = 0; ls_req_we = 0; ls_req_wdata = 0; ls_req_wstrb = 0;
        m_rsp_valid = 1; m_rsp_rdata = 32'hBAD0BAD0; ls_rsp_ready = 1; if_rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            m_req_ready = (i == 4);
            @(negedge clk);
            chk($sformatf("t3_valid%0d", i), m_req_valid, 1);
            chk($sformatf("t3_payload%0d", i),
                {m_req_addr, m_req_we, m_req_wstrb}, {32'h2000, 1'b1, 4'hF});
            chk($sformatf("t3_wdata%0d", i), m_req_wdata, 32'hDEADBEEF);
            chk($sformatf("t3_spurious%0d", i), {m_rsp_ready, ls_rsp_valid, if_rsp_valid}, 0);
            tick();
        end
        m_req_ready = 0; m_rsp_valid = 0;
        @(negedge clk);
        chk("t3_wait_rsp", {m_req_valid, ls_rsp_valid, if_rsp_valid}, 0);
        tick();
        m_rsp_valid = 1; m_rsp_rdata = 32'h12345678;
        @(negedge clk);
        chk("t3_ls_rsp", {ls_rsp_valid, if_rsp_valid, m_rsp_ready}, 3'b101);
        chk("t3_ls_rdata", ls_rsp_rdata, 32'h12345678);
        chk("t3_if_rdata", if_rsp_rdata, 0);
        tick();
        idle_inputs();

        // Response backpressure from IF
        do_reset();
        if_req_valid = 1; if_req_addr = 32'h300;
        @(negedge clk);
        chk("t5_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 0; m_req_ready = 1;
        @(negedge clk);
        tick();
        m_req_ready = 0; m_rsp_valid = 1; m_rsp_rdata = 32'hCAFEF00D;
        if_rsp_ready = 0; ls_req_valid = 1; ls_req_addr = 32'h44;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("t5_stall%0d", i),
                {m_rsp_ready, if_rsp_valid, ls_req_ready, if_req_ready}, 4'b0100);
            chk($sformatf("t5_rdata%0d", i), if_rsp_rdata, 32'hCAFEF00D);
            tick();
        end
        if_rsp_ready = 1;
        @(negedge clk);
        chk("t5_release", {m_rsp_ready, if_rsp_valid}, 2'b11);
        tick();
        m_rsp_valid = 0; if_rsp_ready = 0;
        @(negedge clk);
        chk("t5_next_grant", ls_req_ready, 1);
        #1 ls_req_valid = 0;
        tick();

        // Reset asserted while a request is on the port
        do_reset();
        if_req_valid = 1; if_req_addr = 32'h500;
        @(negedge clk);
        tick();
        if_req_valid = 0;
        @(negedge clk);
        chk("t1_req_up", m_req_valid, 1);
        #1 rst_n = 0;
        #1;
        chk("t1_async_drop", {m_req_valid, m_req_addr}, 0);
        tick();
        tick();
        rst_n = 1; m_rsp_valid = 1; m_rsp_rdata = 32'h77; if_rsp_ready = 1; ls_rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t1_no_rsp%0d", i),
                {if_rsp_valid, ls_rsp_valid, m_rsp_ready, m_req_valid}, 0);
            tick();
        end
        idle_inputs();

        // Contention order: three requests from each side
        do_reset();
        ni = 3; nl = 3; ng = 0;
        order = '{default: 0};
        m_req_ready = 1; m_rsp_valid = 1; if_rsp_ready = 1; ls_rsp_ready = 1;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            if_req_valid = (ni > 0);
            ls_req_valid = (nl > 0);
            @(negedge clk);
            if (if_req_valid && if_req_ready) begin
                order[ng] = 0; ng++; ni--;
            end else if (ls_req_valid && ls_req_ready) begin
                order[ng] = 1; ng++; nl--;
            end
            tick();
        end
        chk("t4_grants", ng, 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t4_owner%0d", k), order[k], exp_order[k]);
        idle_inputs();

        // Randomized traffic against the transaction model
        do_reset();
        if_pend = 0; ls_pend = 0; phase = 0; rr_last = 0; ntx = 0; dly = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_a = {26'd0, 4'($urandom), 2'b00};
            end
            if (!ls_pend && $urandom_range(0, 2) == 0) begin
                ls_pend = 1; ls_a = {26'd0, 4'($urandom), 2'b00};
                ls_we = 1'($urandom); ls_wd = $urandom; ls_ws = 4'($urandom);
            end
            if_req_valid = if_pend;
            if_req_addr  = if_pend ? if_a : $urandom;
            ls_req_valid = ls_pend;
            ls_req_addr  = ls_pend ? ls_a : $urandom;
            ls_req_we    = ls_pend ? ls_we : 1'($urandom);
            ls_req_wdata = ls_pend ? ls_wd : $urandom;
            ls_req_wstrb = ls_pend ? ls_ws : 4'($urandom);
            m_req_ready  = ($urandom_range(0, 2) != 0);
            if_rsp_ready = ($urandom_range(0, 3) != 0);
            ls_rsp_ready = ($urandom_range(0, 3) != 0);
            drv_rdata = $urandom;
            if (phase == 2 && dly == 0) begin
                m_rsp_valid = 1; drv_rdata = rsp_val;
            end else if (phase != 2) begin
                m_rsp_valid = ($urandom_range(0, 3) == 0);
            end else begin
                m_rsp_valid = 0;
            end
            m_rsp_rdata = drv_rdata;
            @(negedge clk);

            win_ls = 0; win_if = 0;
            if (phase == 0) begin
`ifdef MEM_ARB_RR_EN
                win_ls = ls_pend && (!if_pend || !rr_last);
`else
                win_ls = ls_pend;
`endif
                win_if = if_pend && !win_ls;
            end
            chk("rnd_if_req_ready", if_req_ready, win_if);
            chk("rnd_ls_req_ready", ls_req_ready, win_ls);
            chk("rnd_m_req_valid", m_req_valid, phase == 1);
            if (phase == 1) begin
                chk("rnd_m_req_addr", m_req_addr, t_addr);
                chk("rnd_m_req_ctl", {m_req_we, m_req_wstrb}, {t_we, t_ws});
                chk("rnd_m_req_wdata", m_req_wdata, t_wd);
            end
            exp_mrr = (phase == 2) && (t_own ? ls_rsp_ready : if_rsp_ready);
            chk("rnd_m_rsp_ready", m_rsp_ready, exp_mrr);
            chk("rnd_if_rsp_valid", if_rsp_valid, (phase == 2) && !t_own && m_rsp_valid);
            chk("rnd_ls_rsp_valid", ls_rsp_valid, (phase == 2) && t_own && m_rsp_valid);
            if (phase == 2) begin
                chk("rnd_if_rdata", if_rsp_rdata, t_own ? 32'h0 : drv_rdata);
                chk("rnd_ls_rdata", ls_rsp_rdata, t_own ? drv_rdata : 32'h0);
            end

            case (phase)
                0: if (win_ls || win_if) begin
                    t_own = win_ls;
                    if (win_ls) begin
                        t_addr = ls_a; t_we = ls_we; t_wd = ls_wd; t_ws = ls_ws;
                        ls_pend = 0;
                    end else begin
                        t_addr = if_a; t_we = 0; t_wd = 0; t_ws = 0;
                        if_pend = 0;
                    end
                    rr_last = win_ls;
                    phase = 1;
                end
                1: if (m_req_ready) begin
                    phase = 2;
                    dly = $urandom_range(0, 2);
                    rsp_val = t_we ? $urandom : mem_rd(t_addr);
                end
                default: if (dly > 0) begin
                    dly--;
                end else if (exp_mrr) begin
                    if (t_we) mem_wr(t_addr, t_wd, t_ws);
                    phase = 0;
                    ntx++;
                end
            endcase
            tick();
        end
        chk("rnd_progress", ntx > 200, 1);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (if_*) and the load/store requester (ls_*).
- Sits between the IF/MEM pipeline stages and the memory bus.
- Uses the same valid/ready handshake as the pipeline stages, with one transaction in flight at a time.
- Latches the granted request, drives it onto the memory port, then routes the response back to the owner.

Parameters:
AW, 32, address width
DW, 32, data width (must be 32; wstrb is 4 bits)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted
if_req_addr  in  AW  fetch address
if_rsp_valid  out  1  fetch response valid
if_rsp_ready  in  1  fetch response accepted
if_rsp_rdata  out  DW  fetch read data
ls_req_valid  in  1  load/store request valid
ls_req_ready  out  1  load/store request accepted
ls_req_addr  in  AW  load/store address
ls_req_we  in  1  1 = store
ls_req_wdata  in  DW  store data
ls_req_wstrb  in  4  store byte enables
ls_rsp_valid  out  1  load/store response valid (loads and stores both respond)
ls_rsp_ready  in  1  load/store response accepted
ls_rsp_rdata  out  DW  load data
m_req_valid  out  1  memory request valid (registered)
m_req_ready  in  1  memory accepts request
m_req_addr  out  AW  registered address
m_req_we  out  1  registered write enable
m_req_wdata  out  DW  registered write data
m_req_wstrb  out  4  registered byte enables
m_rsp_valid  in  1  memory response valid
m_rsp_ready  out  1  response accepted
m_rsp_rdata  in  DW  memory read data

Behaviour:
- States: IDLE, REQ, RESP. Owner register: 0 = IF, 1 = LS.
- Reset (async, rst_n=0):
  - state=IDLE, owner=0, last-grant=IF.
  - m_req_valid=0; m_req_addr/we/wdata/wstrb=0.
  - All *_rsp_valid=0, all *_req_ready=0, m_rsp_ready=0.
- Reset mid-transaction: the in-flight transaction is dropped with no response to the requester. The memory side must be reset with the same rst_n.
- IDLE:
  - Arbitrate combinationally. Only the winner's req_ready=1; the loser's req_ready=0.
  - Fixed priority: LS wins over IF when both are valid.
  - On handshake (winner valid & ready): latch addr/we/wdata/wstrb and owner, go to REQ. m_req_valid=1 from the next cycle.
  - IF requests latch we=0, wdata=0, wstrb=0.
  - No request: stay in IDLE.
- REQ:
  - m_req_valid=1 with stable payload until m_req_ready=1, then go to RESP.
  - Both req_ready=0.
- RESP:
  - m_rsp_ready = owner's rsp_ready.
  - Owner's rsp_valid = m_rsp_valid; owner's rsp_rdata = m_rsp_rdata (combinational pass-through).
  - Non-owner rsp_valid=0; non-owner rdata=0.
  - On m_rsp_valid & m_rsp_ready: go to IDLE.
- Outside RESP: m_rsp_ready=0 and m_rsp_valid is ignored. Memory must not respond in the same cycle it accepts a request.
- Minimum occupancy: 3 cycles per transaction (accept, issue, respond). Back-to-back: the next grant is possible in the cycle after the response handshake.
- Requester-side contract: a requester keeps req_valid and its payload stable until req_ready. The arbiter does not rely on this after the latch.
- last-grant register updates to the owner on each IDLE handshake. It is unused unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin when both requesters are valid in IDLE. The grant goes to the requester not in last-grant, so neither requester waits more than one transaction.
- Undefined: fixed LS-over-IF priority as above. The last-grant register may be optimized away.

Test Plan:
1. Reset held low 3 cycles, then released → all outputs 0, state IDLE. Assert rst_n=0 during REQ → m_req_valid=0 within the same cycle; no rsp_valid follows.
2. IF only, addr=0x0000_0100, memory ready immediately, rdata=0x0000_0013 one cycle later:
   - if_req_ready=1 at T; m_req_valid=1 at T+1 with addr=0x100, we=0.
   - if_rsp_valid=1 with 0x13 at T+2; back in IDLE at T+3.
3. LS store addr=0x2000, wdata=0xDEADBEEF, wstrb=0xF, m_req_ready held 0 for 4 cycles → payload stable all 4 cycles; ls_rsp_valid only after m_rsp_valid; if_rsp_valid stays 0.
4. IF and LS valid together, 3 back-to-back each:
   - Without MEM_ARB_RR_EN: order LS, LS, LS, IF, IF, IF.
   - With MEM_ARB_RR_EN: order LS, IF, LS, IF, LS, IF.
5. Response backpressure: owner IF holds if_rsp_ready=0 for 2 cycles while m_rsp_valid=1 → m_rsp_ready=0 for those cycles; no new grant; rdata passes through; completes when ready=1.
6. Spurious m_rsp_valid=1 in IDLE and REQ → m_rsp_ready=0; no rsp_valid to either requester; state unaffected.
